redmule_tile_ctrl: RTL and testbench

Parametrised tile-sequencing controller for the RedMulE datapath. After a start pulse it drives the weight-row scheduler, the engine accumulate/flush controls and the Z-buffer fill/store handshake for a programmable number of output tiles. It then signals completion to the cores. Compared with the previous controller, it adds:

- a configurable array height and drain latency;
- a Y-preload accumulate mode;
- a programmable per-tile row count latched at start;
- an abort path;
- a zero-work bypass.

It sits between the HWPE register file/slave and the scheduler, engine and Z buffer.

---
 rtl/redmule_tile_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_redmule_tile_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_ctrl.sv
`default_nettype none
// redmule_tile_ctrl -- tile sequencer driving the RedMulE weight scheduler, engine and Z buffer.
// Revision: 1.0
module redmule_tile_ctrl #(
  parameter int N_CORES      = 8,
  parameter int Height       = 4,
  parameter int DRAIN_CYCLES = Height - 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_W-1:0]     w_iters_i,
  input  logic [CNT_W-1:0]     tot_tiles_i,
  input  logic                 y_acc_i,
  input  logic                 w_loaded_i,
  input  logic                 reg_enable_i,
  input  logic                 z_full_i,
  input  logic                 z_empty_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*N_CORES-1:0] evt_o,
  output logic                 first_load_o,
  output logic                 storing_o,
  output logic                 finished_o,
  output logic                 sched_rst_o,
  output logic                 flush_o,
  output logic                 accumulate_o,
  output logic                 w_shift_o,
  output logic                 z_fill_o,
  output logic                 z_buffer_clk_en_o,
  output logic [CNT_W-1:0]     tile_idx_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STARTING  = 3'd1;
  localparam logic [2:0] S_COMPUTING = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_BUFFERING = 3'd4;
  localparam logic [2:0] S_STORING   = 3'd5;
  localparam logic [2:0] S_FINISHED  = 3'd6;

  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HEIGHT_ROWS = CNT_W'(Height);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] w_iters_q;
  logic [CNT_W-1:0] tot_tiles_q;
  logic             y_acc_q;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] tile_cnt;
  logic             acc_q;

  logic             load_ok;
  logic [CNT_W-1:0] row_adv;
  logic             rows_done;
  logic             drain_last;
  logic             last_tile;
  logic             abort_hit;

  // Rows are capped at the tile size so prefetch can never overrun the counter.
  assign load_ok    = w_loaded_i && (row_cnt < w_iters_q);
  assign row_adv    = row_cnt + (load_ok ? ONE_CNT : '0);
  assign rows_done  = (row_adv >= w_iters_q);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  assign last_tile  = (tile_cnt == (tot_tiles_q - ONE_CNT));
  assign abort_hit  = abort_i && (state != S_IDLE) && (state != S_FINISHED);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort_hit) begin
      state_next = S_FINISHED;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state_next = (w_iters_i == '0 || tot_tiles_i == '0) ? S_FINISHED : S_STARTING;
          end
        end
        S_STARTING:  if (w_loaded_i) state_next = S_COMPUTING;
        S_COMPUTING: if (rows_done) state_next = S_DRAIN;
        S_DRAIN:     if (reg_enable_i && drain_last) state_next = S_BUFFERING;
        S_BUFFERING: if (z_full_i) state_next = S_STORING;
        S_STORING: begin
          if (z_empty_i) state_next = last_tile ? S_FINISHED : S_COMPUTING;
        end
        S_FINISHED:  state_next = S_IDLE;
        default:     state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_iters_q   <= '0;
      tot_tiles_q <= '0;
      y_acc_q     <= 1'b0;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      tile_cnt    <= '0;
      acc_q       <= 1'b0;
    end else if (abort_hit) begin
      acc_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          row_cnt  <= '0;
          tile_cnt <= '0;
          if (start_i) begin
            w_iters_q   <= w_iters_i;
            tot_tiles_q <= tot_tiles_i;
            y_acc_q     <= y_acc_i;
          end
        end
        S_STARTING: begin
          if (w_loaded_i) begin
            row_cnt <= ONE_CNT;
            acc_q   <= y_acc_q;
          end
        end
        S_COMPUTING: begin
          row_cnt <= row_adv;
          if (y_acc_q || row_adv >= HEIGHT_ROWS) acc_q <= 1'b1;
          if (rows_done) drain_cnt <= '0;
        end
        S_DRAIN: begin
          if (reg_enable_i) begin
            if (drain_last) begin
              acc_q   <= 1'b0;
              row_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt + ONE_CNT;
            end
          end
        end
        // Rows loaded while the Z buffer fills count toward the next tile.
        S_BUFFERING: row_cnt <= row_adv;
        S_STORING: begin
          if (z_empty_i && !last_tile) begin
            tile_cnt <= tile_cnt + ONE_CNT;
            acc_q    <= y_acc_q;
          end
        end
        S_FINISHED: begin
          row_cnt   <= '0;
          drain_cnt <= '0;
          tile_cnt  <= '0;
          acc_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o            = 1'b0;
    done_o            = 1'b0;
    first_load_o      = 1'b0;
    storing_o         = 1'b0;
    finished_o        = 1'b0;
    sched_rst_o       = 1'b0;
    flush_o           = 1'b0;
    w_shift_o         = 1'b0;
    z_fill_o          = 1'b0;
    z_buffer_clk_en_o = 1'b0;
    case (state)
      S_STARTING: begin
        busy_o       = 1'b1;
        first_load_o = 1'b1;
      end
      S_COMPUTING: begin
        busy_o    = 1'b1;
        w_shift_o = 1'b1;
      end
      S_DRAIN: busy_o = 1'b1;
      S_BUFFERING: begin
        busy_o            = 1'b1;
        z_buffer_clk_en_o = 1'b1;
        z_fill_o          = reg_enable_i;
      end
      S_STORING: begin
        busy_o     = 1'b1;
        storing_o  = 1'b1;
        finished_o = last_tile;
      end
      S_FINISHED: begin
        done_o      = 1'b1;
        flush_o     = 1'b1;
        sched_rst_o = 1'b1;
        finished_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign accumulate_o = acc_q & reg_enable_i;
  assign tile_idx_o   = tile_cnt;

  for (genvar k = 0; k < N_CORES; k++) begin : g_evt
    assign evt_o[2*k]   = done_o;
    assign evt_o[2*k+1] = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_redmule_tile_ctrl.sv
`default_nettype none
// tb_redmule_tile_ctrl -- randomized jobs checked against a phase-timeline model of the controller.
module tb_redmule_tile_ctrl;

  localparam int NC = 8;
  localparam int H  = 4;
  localparam int DC = H - 2;
  localparam int CW = 16;
  localparam int OW = 11 + 2*NC + CW;

  localparam int B_BUSY = OW - 1;
  localparam int B_DONE = OW - 2;
  localparam int B_FL   = OW - 3;
  localparam int B_ST   = OW - 4;
  localparam int B_ACC  = OW - 8;
  localparam int B_SH   = OW - 9;
  localparam int B_ZC   = OW - 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, w_loaded, reg_enable, z_full, z_empty, y_acc;
  logic [CW-1:0] w_iters, tot_tiles;
  logic busy, done, first_load, storing, finished, sched_rst, flush;
  logic accumulate, w_shift, z_fill, z_clk_en;
  logic [2*NC-1:0] evt;
  logic [CW-1:0] tile_idx;
  logic [OW-1:0] obs_now;

  assign obs_now = {busy, done, first_load, storing, finished, sched_rst, flush,
                    accumulate, w_shift, z_fill, z_clk_en, evt, tile_idx};

  redmule_tile_ctrl #(.N_CORES(NC), .Height(H), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .w_iters_i(w_iters), .tot_tiles_i(tot_tiles), .y_acc_i(y_acc),
    .w_loaded_i(w_loaded), .reg_enable_i(reg_enable), .z_full_i(z_full), .z_empty_i(z_empty),
    .busy_o(busy), .done_o(done), .evt_o(evt), .first_load_o(first_load),
    .storing_o(storing), .finished_o(finished), .sched_rst_o(sched_rst), .flush_o(flush),
    .accumulate_o(accumulate), .w_shift_o(w_shift), .z_fill_o(z_fill),
    .z_buffer_clk_en_o(z_clk_en), .tile_idx_o(tile_idx)
  );

  typedef enum int {P_IDLE, P_START, P_COMP, P_DRAIN, P_BUF, P_STORE, P_FIN} phase_e;

  typedef struct packed {
    logic          start;
    logic          abort;
    logic          wl;
    logic          en;
    logic          zf;
    logic          ze;
    logic          ya;
    logic [CW-1:0] wi;
    logic [CW-1:0] tt;
  } stim_t;

  stim_t         sq[$];
  logic [OW-1:0] eq[$];
  logic [OW-1:0] mq[$];
  logic [OW-1:0] oq[$];

  int total = 0;
  int bad   = 0;

  // Output table for each job phase.
  function automatic logic [OW-1:0] expect_out(phase_e p, logic acc, logic en,
                                               logic [CW-1:0] tile, logic last);
    logic b = 0, d = 0, fl = 0, st = 0, fi = 0, sr = 0, fu = 0, ac = 0, sh = 0, zf = 0, zc = 0;
    logic [2*NC-1:0] ev = '0;
    logic [CW-1:0]   t  = tile;
    case (p)
      P_IDLE:  t = '0;
      P_START: begin b = 1; fl = 1; end
      P_COMP:  begin b = 1; sh = 1; ac = acc & en; end
      P_DRAIN: begin b = 1; ac = acc & en; end
      P_BUF:   begin b = 1; zc = 1; zf = en; end
      P_STORE: begin b = 1; st = 1; fi = last; end
      P_FIN: begin
        d = 1; fu = 1; sr = 1; fi = 1;
        for (int k = 0; k < NC; k++) ev[2*k] = 1'b1;
      end
      default: ;
    endcase
    return {b, d, fl, st, fi, sr, fu, ac, sh, zf, zc, ev, t};
  endfunction

  function automatic logic ren(int rnd_en);
    return (rnd_en != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic clear();
    sq.delete(); eq.delete(); mq.delete(); oq.delete();
  endtask

  task automatic emit(input phase_e p, input logic s, input logic wl, input logic en,
                      input logic zf, input logic ze, input logic acc, input int tile,
                      input logic last, input int wi, input int tt, input logic ya);
    stim_t x;
    logic [OW-1:0] m;
    x.start = s;
    x.abort = 1'b0;
    x.wl    = wl;
    x.en    = en;
    x.zf    = (p == P_BUF)   ? zf : 1'($urandom_range(0, 1));
    x.ze    = (p == P_STORE) ? ze : 1'($urandom_range(0, 1));
    if (s) begin
      x.wi = CW'(wi); x.tt = CW'(tt); x.ya = ya;
    end else begin
      x.wi = CW'($urandom); x.tt = CW'($urandom); x.ya = 1'($urandom_range(0, 1));
      if (p != P_IDLE && $urandom_range(0, 7) == 0) x.start = 1'b1;
    end
    m = '1;
    if (p == P_FIN) m[CW-1:0] = '0;
    sq.push_back(x);
    eq.push_back(expect_out(p, acc, en, CW'(tile), last));
    mq.push_back(m);
  endtask

  // Appends one whole job (stimulus and expected outputs) to the timeline.
  task automatic build_job(input int wi, input int tt, input logic ya, input int pf,
                           input int stall, input int rnd_en, input int max_gap);
    int rows, en_cnt, k, len;
    logic acc, en;
    emit(P_IDLE, 1, 0, 1, 0, 0, 0, 0, 0, wi, tt, ya);
    if (wi == 0 || tt == 0) begin
      emit(P_FIN, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      emit(P_IDLE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    repeat ($urandom_range(0, max_gap)) emit(P_START, 0, 0, ren(rnd_en), 0, 0, 0, 0, 0, 0, 0, 0);
    emit(P_START, 0, 1, ren(rnd_en), 0, 0, 0, 0, 0, 0, 0, 0);
    rows = 1;
    acc  = ya;
    for (int tile = 0; tile < tt; tile++) begin
      if (rows >= wi) begin
        emit(P_COMP, 0, 0, ren(rnd_en), 0, 0, acc, tile, 0, 0, 0, 0);
        if (rows >= H) acc = 1'b1;
      end else begin
        while (rows < wi) begin
          repeat ($urandom_range(0, max_gap)) begin
            emit(P_COMP, 0, 0, ren(rnd_en), 0, 0, acc, tile, 0, 0, 0, 0);
            if (rows >= H) acc = 1'b1;
          end
          emit(P_COMP, 0, 1, ren(rnd_en), 0, 0, acc, tile, 0, 0, 0, 0);
          rows++;
          if (rows >= H) acc = 1'b1;
        end
      end
      en_cnt = 0;
      k = 0;
      while (en_cnt < DC) begin
        en = (k < stall) ? 1'b0 : ren(rnd_en);
        emit(P_DRAIN, 0, 0, en, 0, 0, acc, tile, 0, 0, 0, 0);
        if (en) en_cnt++;
        k++;
      end
      acc  = 1'b0;
      rows = 0;
      len  = pf + $urandom_range(0, 2) + 1;
      for (int i = 0; i < len; i++) begin
        emit(P_BUF, 0, 1'(i < pf), ren(rnd_en), 1'(i == len - 1), 0, acc, tile, 0, 0, 0, 0);
        if (i < pf) rows++;
      end
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        emit(P_STORE, 0, 0, ren(rnd_en), 0, 1'(i == len - 1), acc, tile, 1'(tile == tt - 1), 0, 0, 0);
      if (tile == tt - 1) begin
        emit(P_FIN, 0, 0, 1, 0, 0, 0, tile, 1, 0, 0, 0);
        emit(P_IDLE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        acc = ya;
      end
    end
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; abort = 0; w_loaded = 0; reg_enable = 0;
    z_full = 0; z_empty = 0; y_acc = 0; w_iters = '0; tot_tiles = '0;
  endtask

  task automatic play();
    oq.delete();
    foreach (sq[k]) begin
      rst = 0; start = sq[k].start; abort = sq[k].abort; w_loaded = sq[k].wl;
      reg_enable = sq[k].en; z_full = sq[k].zf; z_empty = sq[k].ze;
      y_acc = sq[k].ya; w_iters = sq[k].wi; tot_tiles = sq[k].tt;
      #1;
      oq.push_back(obs_now);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic drv(input logic s, input logic ab, input logic wl, input logic en,
                     input logic zf, input logic ze, input int wi, input int tt);
    rst = 0; start = s; abort = ab; w_loaded = wl; reg_enable = en;
    z_full = zf; z_empty = ze; y_acc = 0; w_iters = CW'(wi); tot_tiles = CW'(tt);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; start = 1; w_iters = 16'd5; tot_tiles = 16'd1;
    tick(); tick();
    total++;
    if (obs_now !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", obs_now); end
    idle_inputs();
    tick();
    total++;
    if (obs_now !== '0) begin bad++; $display("FAIL reset_idle: got %h want 0", obs_now); end
  endtask

  task automatic test_basic();
    int nd = 0;
    clear();
    build_job(8, 1, 0, 0, 0, 0, 2);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL basic cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
    foreach (oq[k]) nd += int'(oq[k][B_DONE]);
    total++;
    if (nd !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    total++;
    if (oq[0][B_FL] !== 1'b0 || oq[1][B_FL] !== 1'b1) begin
      bad++; $display("FAIL basic_first_load: got %b%b want 01", oq[0][B_FL], oq[1][B_FL]);
    end
  endtask

  task automatic test_multi_tile();
    logic [CW-1:0] mx = '0;
    clear();
    build_job(8, 3, 0, 2, 0, 1, 1);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL multi cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
    foreach (oq[k]) if (oq[k][B_BUSY] && oq[k][CW-1:0] > mx) mx = oq[k][CW-1:0];
    total++;
    if (mx !== 16'd2) begin bad++; $display("FAIL multi_tile_max: got %0d want 2", mx); end
  endtask

  task automatic test_y_mode();
    int split, na = 0;
    clear();
    build_job(2, 2, 1, $urandom_range(0, 2), 0, 1, 1);
    split = sq.size();
    build_job(2, 2, 0, $urandom_range(0, 2), 0, 1, 1);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL y_mode cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
    for (int k = split; k < oq.size(); k++) na += int'(oq[k][B_ACC]);
    total++;
    if (na !== 0) begin bad++; $display("FAIL short_no_acc: got %0d want 0", na); end
  endtask

  task automatic test_stall();
    int nd = 0;
    clear();
    build_job(8, 1, 0, 0, 5, 0, 0);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL stall cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
    foreach (oq[k])
      if (oq[k][B_BUSY] && !oq[k][B_FL] && !oq[k][B_SH] && !oq[k][B_ZC] && !oq[k][B_ST]) nd++;
    total++;
    if (nd !== DC + 5) begin bad++; $display("FAIL stall_drain_len: got %0d want %0d", nd, DC + 5); end
  endtask

  task automatic test_zero_work();
    int nf = 0;
    clear();
    build_job(0, $urandom_range(1, 5), 0, 0, 0, 1, 1);
    build_job($urandom_range(1, 5), 0, 1, 0, 0, 1, 1);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL zero_work cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
    foreach (oq[k]) nf += int'(oq[k][B_FL]);
    total++;
    if (nf !== 0) begin bad++; $display("FAIL zero_first_load: got %0d want 0", nf); end
  endtask

  task automatic test_back_to_back();
    int wi;
    clear();
    for (int j = 0; j < 6; j++) begin
      wi = $urandom_range(1, 10);
      build_job(wi, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, (wi < 3) ? wi : 3), $urandom_range(0, 3), 1, 2);
    end
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL back_to_back cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
  endtask

  task automatic test_abort();
    drv(0, 1, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_idle: got %b want 00", {busy, done}); end
    drv(1, 0, 0, 1, 0, 0, 2, 2); tick();
    drv(0, 0, 1, 1, 0, 0, 0, 0);
    total++;
    if (first_load !== 1'b1) begin bad++; $display("FAIL abort_starting: got %b want 1", first_load); end
    tick();
    drv(0, 0, 1, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 1, 0, 0, 0);
    total++;
    if (z_clk_en !== 1'b1) begin bad++; $display("FAIL abort_buffering: got %b want 1", z_clk_en); end
    tick();
    drv(0, 1, 0, 1, 0, 0, 0, 0);
    total++;
    if (storing !== 1'b1) begin bad++; $display("FAIL abort_storing: got %b want 1", storing); end
    tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    total++;
    if ({done, flush, sched_rst, busy} !== 4'b1110 || evt !== 16'h5555) begin
      bad++; $display("FAIL abort_finish: got %b evt %h want 1110 evt 5555", {done, flush, sched_rst, busy}, evt);
    end
    tick();
    total++;
    if (obs_now !== '0) begin bad++; $display("FAIL abort_back_idle: got %h want 0", obs_now); end
    drv(1, 0, 0, 1, 0, 0, 4, 1); tick();
    drv(0, 1, 0, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL abort_from_start: got %b want 1", done); end
    tick();
    total++;
    if (obs_now !== '0) begin bad++; $display("FAIL abort_start_idle: got %h want 0", obs_now); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    drv(1, 0, 0, 1, 0, 0, 8, 1); tick();
    drv(0, 0, 1, 1, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 1, 0, 0, 0, 0);
    total++;
    if (w_shift !== 1'b1) begin bad++; $display("FAIL reset_mid_comp: got %b want 1", w_shift); end
    rst = 1;
    tick();
    total++;
    if (obs_now !== '0) begin bad++; $display("FAIL reset_mid_zero: got %h want 0", obs_now); end
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 1, 1, 1, 0, 0);
      nd += int'(done) + int'(busy);
      tick();
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL reset_mid_quiet: got %0d want 0", nd); end
    clear();
    build_job(3, 1, 0, 0, 0, 1, 1);
    play();
    foreach (eq[k]) begin
      total++;
      if (((oq[k] ^ eq[k]) & mq[k]) !== '0) begin
        bad++; $display("FAIL reset_mid_rerun cycle %0d: got %h want %h", k, oq[k], eq[k]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_basic();
    test_multi_tile();
    test_y_mode();
    test_stall();
    test_zero_work();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
